// File: rtl/instr_register_calc_if.sv
// Bus bundle for the instruction register: write strobe/operands, read request,
// and the registered read-back and status outputs.
interface instr_register_calc_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  load_en;
    logic                  auto_wr;
    logic [3:0]            opcode;
    logic [DATA_W-1:0]     operand_a;
    logic [DATA_W-1:0]     operand_b;
    logic [ADDR_W-1:0]     write_pointer;
    logic                  read_en;
    logic [ADDR_W-1:0]     read_pointer;
    logic                  rd_valid;
    logic [3:0]            rd_opcode;
    logic [DATA_W-1:0]     rd_operand_a;
    logic [DATA_W-1:0]     rd_operand_b;
    logic [2*DATA_W-1:0]   rd_result;
    logic                  rd_err;
    logic [ADDR_W-1:0]     auto_ptr;
    logic [15:0]           wr_count;

    modport master (
        output load_en, auto_wr, opcode, operand_a, operand_b, write_pointer,
               read_en, read_pointer,
        input  rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result,
               rd_err, auto_ptr, wr_count
    );

    modport slave (
        input  load_en, auto_wr, opcode, operand_a, operand_b, write_pointer,
               read_en, read_pointer,
        output rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result,
               rd_err, auto_ptr, wr_count
    );
endinterface

// File: rtl/instr_register_calc.sv
// Instruction register that stores {opcode, a, b, result, err} per entry with the
// result computed on write, plus a registered read port with a valid flag.
module instr_register_calc #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input logic                  clk,
    input logic                  reset,
    instr_register_calc_if.slave bus
);
    localparam int                RES_W   = 2 * DATA_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    typedef enum logic [3:0] {
        OP_ZERO  = 4'd0,
        OP_PASSA = 4'd1,
        OP_PASSB = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_MULT  = 4'd5,
        OP_DIV   = 4'd6,
        OP_MOD   = 4'd7
    } opcode_e;

    // Returns {err, result}; divide/modulo by zero and illegal opcodes give err with result 0.
    function automatic logic [RES_W:0] calc_result(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [RES_W-1:0] ax;
        logic signed [RES_W-1:0] bx;
        logic signed [RES_W-1:0] res;
        logic                    err;
        ax  = {{DATA_W{a[DATA_W-1]}}, a};
        bx  = {{DATA_W{b[DATA_W-1]}}, b};
        res = '0;
        err = 1'b0;
        case (op)
            OP_ZERO:  res = '0;
            OP_PASSA: res = ax;
            OP_PASSB: res = bx;
            OP_ADD:   res = ax + bx;
            OP_SUB:   res = ax - bx;
            OP_MULT:  res = ax * bx;
            OP_DIV: begin
                if (bx == '0) begin
                    err = 1'b1;
                end else begin
                    res = ax / bx;
                end
            end
            OP_MOD: begin
                if (bx == '0) begin
                    err = 1'b1;
                end else begin
                    res = ax % bx;
                end
            end
            default: err = 1'b1;
        endcase
        return {err, res};
    endfunction

    logic [3:0]        r_mem_op  [DEPTH];
    logic [DATA_W-1:0] r_mem_a   [DEPTH];
    logic [DATA_W-1:0] r_mem_b   [DEPTH];
    logic [RES_W-1:0]  r_mem_res [DEPTH];
    logic              r_mem_err [DEPTH];

    logic [ADDR_W-1:0] r_auto_ptr;
    logic [15:0]       r_wr_count;
    logic              r_rd_valid;
    logic [3:0]        r_rd_opcode;
    logic [DATA_W-1:0] r_rd_a;
    logic [DATA_W-1:0] r_rd_b;
    logic [RES_W-1:0]  r_rd_res;
    logic              r_rd_err;

    logic              w_wr_ok;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_ptr_next;
    logic              w_rd_in_range;
    logic [RES_W-1:0]  w_calc_res;
    logic              w_calc_err;

    // Write decode: pick the target address and reject explicit addresses past the end.
    always_comb begin
        w_wr_addr     = bus.write_pointer;
        w_wr_ok       = 1'b0;
        w_ptr_next    = r_auto_ptr + ADDR_W'(1);
        w_rd_in_range = ({1'b0, bus.read_pointer} < DEPTH_C);
        if (bus.auto_wr) begin
            w_wr_addr = r_auto_ptr;
            w_wr_ok   = bus.load_en;
        end else begin
            w_wr_ok   = bus.load_en && ({1'b0, bus.write_pointer} < DEPTH_C);
        end
        if (r_auto_ptr == LAST_C) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = r_auto_ptr + ADDR_W'(1);
        end
        {w_calc_err, w_calc_res} = calc_result(bus.opcode, bus.operand_a, bus.operand_b);
    end

    // Storage array, auto pointer and saturating write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_op[i]  <= 4'd0;
                r_mem_a[i]   <= '0;
                r_mem_b[i]   <= '0;
                r_mem_res[i] <= '0;
                r_mem_err[i] <= 1'b0;
            end
            r_auto_ptr <= '0;
            r_wr_count <= 16'd0;
        end else begin
            if (w_wr_ok) begin
                r_mem_op[w_wr_addr]  <= bus.opcode;
                r_mem_a[w_wr_addr]   <= bus.operand_a;
                r_mem_b[w_wr_addr]   <= bus.operand_b;
                r_mem_res[w_wr_addr] <= w_calc_res;
                r_mem_err[w_wr_addr] <= w_calc_err;
                if (bus.auto_wr) begin
                    r_auto_ptr <= w_ptr_next;
                end
                if (r_wr_count != 16'hFFFF) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end
            end
        end
    end

    // Registered read port; non-blocking update gives read-before-write on a shared address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid  <= 1'b0;
            r_rd_opcode <= 4'd0;
            r_rd_a      <= '0;
            r_rd_b      <= '0;
            r_rd_res    <= '0;
            r_rd_err    <= 1'b0;
        end else begin
            r_rd_valid <= bus.read_en;
            if (bus.read_en) begin
                if (w_rd_in_range) begin
                    r_rd_opcode <= r_mem_op[bus.read_pointer];
                    r_rd_a      <= r_mem_a[bus.read_pointer];
                    r_rd_b      <= r_mem_b[bus.read_pointer];
                    r_rd_res    <= r_mem_res[bus.read_pointer];
                    r_rd_err    <= r_mem_err[bus.read_pointer];
                end else begin
                    r_rd_opcode <= 4'd0;
                    r_rd_a      <= '0;
                    r_rd_b      <= '0;
                    r_rd_res    <= '0;
                    r_rd_err    <= 1'b1;
                end
            end
        end
    end

    assign bus.rd_valid     = r_rd_valid;
    assign bus.rd_opcode    = r_rd_opcode;
    assign bus.rd_operand_a = r_rd_a;
    assign bus.rd_operand_b = r_rd_b;
    assign bus.rd_result    = r_rd_res;
    assign bus.rd_err       = r_rd_err;
    assign bus.auto_ptr     = r_auto_ptr;
    assign bus.wr_count     = r_wr_count;
endmodule

// File: tb/tb_instr_register_calc.sv
// Randomised scoreboard bench: the driver pushes one expected-output record per cycle
// from a behavioural model; an independent monitor pops and compares after each edge.
module tb_instr_register_calc;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 20;
    localparam int ADDR_W = $clog2(DEPTH);

    logic clk;
    logic reset;

    instr_register_calc_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    instr_register_calc #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit      valid;
        int      op;
        longint  a;
        longint  b;
        longint  res;
        bit      err;
        int      ptr;
        int      cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    int     m_op  [DEPTH];
    longint m_a   [DEPTH];
    longint m_b   [DEPTH];
    longint m_res [DEPTH];
    bit     m_err [DEPTH];
    int     m_ptr;
    int     m_cnt;
    exp_t   m_last;

    function automatic void ref_calc(input int op, input longint a, input longint b,
                                     output longint r, output bit e);
        r = 0;
        e = 1'b0;
        case (op)
            0: r = 0;
            1: r = a;
            2: r = b;
            3: r = a + b;
            4: r = a - b;
            5: r = a * b;
            6: if (b == 0) e = 1'b1; else r = a / b;
            7: if (b == 0) e = 1'b1; else r = a % b;
            default: e = 1'b1;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // One clock of stimulus, driven at the falling edge; the expected post-edge state is queued.
    task automatic cycle(input bit rst, input bit ld, input bit aw, input int op,
                         input int a, input int b, input int wp, input bit rd, input int rp);
        exp_t   e;
        longint r;
        bit     er;
        int     addr;
        bit     ok;
        reset             = rst;
        bus.load_en       = ld;
        bus.auto_wr       = aw;
        bus.opcode        = 4'(op);
        bus.operand_a     = a;
        bus.operand_b     = b;
        bus.write_pointer = ADDR_W'(wp);
        bus.read_en       = rd;
        bus.read_pointer  = ADDR_W'(rp);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_op[i] = 0; m_a[i] = 0; m_b[i] = 0; m_res[i] = 0; m_err[i] = 1'b0;
            end
            m_ptr = 0;
            m_cnt = 0;
            e = '{valid: 1'b0, op: 0, a: 0, b: 0, res: 0, err: 1'b0, ptr: 0, cnt: 0};
        end else begin
            e = m_last;
            e.valid = rd;
            if (rd) begin
                if (rp < DEPTH) begin
                    e.op = m_op[rp]; e.a = m_a[rp]; e.b = m_b[rp];
                    e.res = m_res[rp]; e.err = m_err[rp];
                end else begin
                    e.op = 0; e.a = 0; e.b = 0; e.res = 0; e.err = 1'b1;
                end
            end
            addr = aw ? m_ptr : wp;
            ok   = ld && (aw || wp < DEPTH);
            if (ok) begin
                ref_calc(op, longint'(a), longint'(b), r, er);
                m_op[addr] = op; m_a[addr] = longint'(a); m_b[addr] = longint'(b);
                m_res[addr] = r; m_err[addr] = er;
                if (aw) m_ptr = (m_ptr + 1) % DEPTH;
                if (m_cnt < 65535) m_cnt++;
            end
            e.ptr = m_ptr;
            e.cnt = m_cnt;
        end
        m_last = e;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_read(input int rp);
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, rp);
    endtask

    task automatic wr_explicit(input int op, input int a, input int b, input int wp);
        cycle(1'b0, 1'b1, 1'b0, op, a, b, wp, 1'b0, 0);
    endtask

    // Monitor: every cycle the DUT presents a state that is compared with the oldest record.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rd_valid", 64'(bus.rd_valid), 64'(e.valid));
                check("rd_opcode", 64'(bus.rd_opcode), 64'(e.op[3:0]));
                check("rd_operand_a", 64'(bus.rd_operand_a), 64'(e.a[31:0]));
                check("rd_operand_b", 64'(bus.rd_operand_b), 64'(e.b[31:0]));
                check("rd_result", bus.rd_result, e.res);
                check("rd_err", 64'(bus.rd_err), 64'(e.err));
                check("auto_ptr", 64'(bus.auto_ptr), 64'(e.ptr));
                check("wr_count", 64'(bus.wr_count), 64'(e.cnt));
            end
        end
    end

    initial begin
        int wp;
        int waited;
        m_last = '{valid: 1'b0, op: 0, a: 0, b: 0, res: 0, err: 1'b0, ptr: 0, cnt: 0};
        // Reset for two cycles; the read issued during reset must be dropped.
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 0);
        cycle(1'b1, 1'b1, 1'b1, 3, 5, 5, 0, 1'b1, 1);
        for (int i = 0; i < DEPTH; i++) idle_read(i);

        // All legal opcodes with a=7, b=-3 at addresses 0..7.
        for (int i = 0; i < 8; i++) wr_explicit(i, 7, -3, i);
        for (int i = 0; i < 8; i++) idle_read(i);

        // Error and boundary cases.
        wr_explicit(6, 5, 0, 8);
        wr_explicit(7, -9, 0, 9);
        wr_explicit(12, 11, 4, 10);
        wr_explicit(5, int'(32'h8000_0000), int'(32'h8000_0000), 11);
        wr_explicit(7, -9, 4, 12);
        wr_explicit(6, -7, 2, 13);
        for (int i = 8; i < 14; i++) idle_read(i);

        // Same-address read and write in one cycle, then the new value.
        cycle(1'b0, 1'b1, 1'b0, 3, 100, 23, 3, 1'b1, 3);
        idle_read(3);

        // Ignored out-of-range write, out-of-range read, hold with read_en low.
        wr_explicit(1, 55, 66, DEPTH);
        idle_read(DEPTH);
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0);
        for (int i = 0; i < DEPTH; i++) idle_read(i);

        // Randomised traffic: mixed auto/explicit writes, reads anywhere (including past the end).
        for (int n = 0; n < 400; n++) begin
            wp = int'($urandom_range(0, (1 << ADDR_W) - 1));
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) - 10 : int'($urandom),
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom),
                  wp, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? wp : int'($urandom_range(0, (1 << ADDR_W) - 1)));
        end

        // Auto-pointer wrap: DEPTH+2 writes with operand_a = index.
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b1, 1'b1, 1, i, 0, 0, 1'b0, 0);
        idle_read(0);
        idle_read(1);
        idle_read(2);

        // Reset in the middle of back-to-back auto writes with reads in flight.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 3, i, 1, 0, 1'b1, i);
        cycle(1'b1, 1'b1, 1'b1, 3, 9, 9, 0, 1'b1, 2);
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) idle_read(i);
        cycle(1'b0, 1'b1, 1'b1, 4, 3, 8, 0, 1'b1, 0);
        idle_read(0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_register_calc.md
# instr_register_calc

Parametrised instruction register with built-in result calculation. Each write stores an opcode and two signed operands together with the computed result. Writes go either to an explicit address or to an internal auto-increment pointer. A registered read port with a valid flag replaces the combinational read of the previous generation. The block sits under the testbench interface as the DUT, in place of the fixed 32-entry instruction register.

## Interface
- DATA_W, 32, width of each signed operand
- DEPTH, 32, number of entries, ≥2, need not be a power of two
- ADDR_W, $clog2(DEPTH), pointer width (derived, do not override)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- load_en  in  1  write strobe
- auto_wr  in  1  1: write address comes from internal pointer; 0: write address comes from write_pointer
- opcode  in  4  ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7; 8..15 illegal
- operand_a  in  DATA_W  signed operand A
- operand_b  in  DATA_W  signed operand B
- write_pointer  in  ADDR_W  explicit write address
- read_en  in  1  read strobe
- read_pointer  in  ADDR_W  read address
- rd_valid  out  1  read data valid
- rd_opcode  out  4  stored opcode
- rd_operand_a  out  DATA_W  stored operand A
- rd_operand_b  out  DATA_W  stored operand B
- rd_result  out  2*DATA_W  stored signed result
- rd_err  out  1  stored error flag
- auto_ptr  out  ADDR_W  current internal write pointer
- wr_count  out  16  accepted writes since reset, saturates at 65535

## Operation
**Entry format:** each entry holds {opcode, operand_a, operand_b, result, err}.

**Result rules.** Operands are sign-extended to 2*DATA_W before arithmetic.
- ZERO → 0
- PASSA → a
- PASSB → b
- ADD → a+b
- SUB → a−b
- MULT → full 2*DATA_W signed product
- DIV → a/b, truncated toward zero
- MOD → a%b, sign follows a

**Errors.** err=1 for DIV or MOD with b=0 (result forced to 0), and for an illegal opcode (result 0, opcode stored as given). Otherwise err=0.

**Write path** (load_en=1):
- Target address is auto_ptr if auto_wr=1, else write_pointer.
- A write_pointer ≥ DEPTH is ignored: no write, wr_count unchanged, auto_ptr unchanged.
- When auto_wr=1, auto_ptr increments and wraps DEPTH−1 → 0.
- When auto_wr=0, auto_ptr does not move.
- wr_count increments on every accepted write.

**Read path** (read_en=1):
- Outputs capture the entry at read_pointer; rd_valid=1 on the next cycle.
- read_pointer ≥ DEPTH: rd_valid=1, all data 0, rd_err=1.
- read_en=0: rd_valid=0 and data outputs hold their last value.

**Simultaneous read and write, same address:** the read returns the old contents (read-before-write). The new contents are visible on the next read.

**Reset:** overrides load_en and read_en in the same cycle.
- All entries cleared to zero.
- auto_ptr=0, wr_count=0, rd_valid=0, all rd_* outputs=0.

## Timing
- Write: the entry and its result update on the rising edge where load_en=1. Result calculation completes in that same cycle, so there is no result latency.
- Read: data and rd_valid appear one cycle after read_en, registered. Back-to-back reads are allowed every cycle, giving throughput of 1 read/cycle.
- auto_ptr and wr_count update on the same edge as the write.
- Reset asserted mid-stream: the next cycle behaves exactly as after power-up. A read issued in the reset cycle is dropped (rd_valid=0).
- Writes and reads are independent; both may occur every cycle.

## Test plan
- **Reset values:** hold reset 2 cycles, then read addresses 0..DEPTH−1 → every read returns rd_valid=1, all data 0, rd_err=0. After reset, auto_ptr=0 and wr_count=0.
- **Explicit writes, all opcodes:** write a=7, b=−3 with opcodes 0..7 to addresses 0..7, then read back. Required results: 0, 7, −3, 4, 10, −21, −2, 1; all err=0.
- **Error cases:**
  - DIV a=5, b=0 → result 0, err=1.
  - MOD a=−9, b=0 → result 0, err=1.
  - Opcode 12 → result 0, err=1, rd_opcode=12.
  - MULT a=b=−2^(DATA_W−1) → result 2^(2*DATA_W−2), err=0.
- **Auto-pointer wrap:** with auto_wr=1, perform DEPTH+2 writes using operand_a = index. Required: entries 0 and 1 hold DEPTH and DEPTH+1; auto_ptr=2; wr_count=DEPTH+2.
- **Read/write same address in one cycle:** old value is returned with rd_valid=1 one cycle later; a following read returns the new value.
- **Invalid addresses and mid-stream reset:**
  - Write with write_pointer=DEPTH → no change anywhere.
  - Read with read_pointer=DEPTH → rd_err=1, data 0.
  - Assert reset during back-to-back auto writes → rd_valid=0 in the next cycle; auto_ptr=0 and wr_count=0 after reset.
